// File: rtl/quick_spi_slave.sv
// SPI slave with clk-domain oversampling of sclk/ss_n/mosi.
// Parameterised word widths, bit order and CPOL/CPHA mode.
module quick_spi_slave #(
  parameter int unsigned INCOMING_DATA_WIDTH = 16,
  parameter int unsigned OUTGOING_DATA_WIDTH = 8,
  parameter bit          BITS_ORDER          = 1'b1,
  parameter bit          CPOL                = 1'b0,
  parameter bit          CPHA                = 1'b0,
  parameter logic        MISO_IDLE_VALUE     = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           sclk,
  input  logic                           ss_n,
  input  logic                           mosi,
  output logic                           miso,
  input  logic [OUTGOING_DATA_WIDTH-1:0] outgoing_data,
  output logic [INCOMING_DATA_WIDTH-1:0] incoming_data,
  output logic                           data_valid,
  output logic                           frame_error,
  output logic                           busy
);

  localparam int unsigned IW  = INCOMING_DATA_WIDTH;
  localparam int unsigned OW  = OUTGOING_DATA_WIDTH;
  localparam int unsigned ICW = $clog2(IW + 1);
  localparam int unsigned OCW = $clog2(OW + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [2:0]     sclk_sync_q;
  logic [2:0]     ss_sync_q;
  logic [1:0]     mosi_sync_q;
  logic [1:0]     vld_q;
  logic           arm_q;

  logic [1:0]     state_q, state_d;
  logic [OW-1:0]  tx_sr_q, tx_sr_d;
  logic [OCW-1:0] tx_cnt_q, tx_cnt_d;
  logic [IW-1:0]  rx_sr_q, rx_sr_d;
  logic [ICW-1:0] rx_cnt_q, rx_cnt_d;
  logic           miso_q, miso_d;
  logic           busy_q, busy_d;
  logic [IW-1:0]  in_q, in_d;
  logic           dv_q, dv_d;
  logic           fe_q, fe_d;

  logic sclk_lead, sclk_trail;
  logic ss_fall, ss_rise;
  logic sample_edge, drive_edge;
  logic start;

  function automatic logic tx_bit(input logic [OW-1:0] v);
    return BITS_ORDER ? v[OW-1] : v[0];
  endfunction

  function automatic logic [OW-1:0] tx_shift(input logic [OW-1:0] v);
    return BITS_ORDER ? (v << 1) : (v >> 1);
  endfunction

  function automatic logic [IW-1:0] rx_shift(input logic [IW-1:0] v,
                                             input logic b);
    logic [IW-1:0] bw;
    bw = IW'(b);
    return BITS_ORDER ? ((v << 1) | bw) : ((v >> 1) | (bw << (IW - 1)));
  endfunction

  assign sclk_lead  = (sclk_sync_q[2] == CPOL) && (sclk_sync_q[1] != CPOL);
  assign sclk_trail = (sclk_sync_q[2] != CPOL) && (sclk_sync_q[1] == CPOL);
  assign ss_fall    = ss_sync_q[2] & ~ss_sync_q[1];
  assign ss_rise    = ~ss_sync_q[2] & ss_sync_q[1];

  assign sample_edge = CPHA ? sclk_trail : sclk_lead;
  assign drive_edge  = CPHA ? sclk_lead : sclk_trail;

  // ss_n held low through reset release must not look like a new frame
  assign start = enable & ss_fall & arm_q;

  // Synchronizers; ss_n delay stage frozen in DONE so a fall there is seen in IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= {3{CPOL}};
      ss_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      vld_q       <= 2'b00;
      arm_q       <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
      ss_sync_q[1:0] <= {ss_sync_q[0], ss_n};
      ss_sync_q[2] <= (state_q == S_DONE) ? ss_sync_q[2] : ss_sync_q[1];
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      vld_q       <= {vld_q[0], 1'b1};
      arm_q       <= arm_q | (vld_q[1] & ss_sync_q[1]);
    end
  end

  // Frame FSM and shift datapath next-state
  always_comb begin
    state_d  = state_q;
    tx_sr_d  = tx_sr_q;
    tx_cnt_d = tx_cnt_q;
    rx_sr_d  = rx_sr_q;
    rx_cnt_d = rx_cnt_q;
    miso_d   = miso_q;
    busy_d   = busy_q;
    in_d     = in_q;
    dv_d     = 1'b0;
    fe_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ACTIVE;
          busy_d   = 1'b1;
          rx_sr_d  = '0;
          rx_cnt_d = '0;
          if (!CPHA) begin
            miso_d   = tx_bit(outgoing_data);
            tx_sr_d  = tx_shift(outgoing_data);
            tx_cnt_d = OCW'(1);
          end else begin
            miso_d   = MISO_IDLE_VALUE;
            tx_sr_d  = outgoing_data;
            tx_cnt_d = '0;
          end
        end
      end
      S_ACTIVE: begin
        if (ss_rise) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          miso_d  = MISO_IDLE_VALUE;
        end else begin
          if (sample_edge && (rx_cnt_q < ICW'(IW))) begin
            rx_sr_d  = rx_shift(rx_sr_q, mosi_sync_q[1]);
            rx_cnt_d = rx_cnt_q + ICW'(1);
          end
          if (drive_edge) begin
            if (tx_cnt_q < OCW'(OW)) begin
              miso_d   = tx_bit(tx_sr_q);
              tx_sr_d  = tx_shift(tx_sr_q);
              tx_cnt_d = tx_cnt_q + OCW'(1);
            end else begin
              miso_d = MISO_IDLE_VALUE;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        in_d    = rx_sr_q;
        dv_d    = 1'b1;
        fe_d    = (rx_cnt_q < ICW'(IW));
        busy_d  = 1'b0;
        miso_d  = MISO_IDLE_VALUE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Frame state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      tx_sr_q  <= '0;
      tx_cnt_q <= '0;
      rx_sr_q  <= '0;
      rx_cnt_q <= '0;
      miso_q   <= MISO_IDLE_VALUE;
      busy_q   <= 1'b0;
      in_q     <= '0;
      dv_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_sr_q  <= tx_sr_d;
      tx_cnt_q <= tx_cnt_d;
      rx_sr_q  <= rx_sr_d;
      rx_cnt_q <= rx_cnt_d;
      miso_q   <= miso_d;
      busy_q   <= busy_d;
      in_q     <= in_d;
      dv_q     <= dv_d;
      fe_q     <= fe_d;
    end
  end

  assign miso          = miso_q;
  assign busy          = busy_q;
  assign incoming_data = in_q;
  assign data_valid    = dv_q;
  assign frame_error   = fe_q;

endmodule

// File: tb/tb_quick_spi_slave.sv
// Directed bench for quick_spi_slave: five instances covering
// the four CPOL/CPHA modes (MSB first) and an LSB-first slave.
module tb_quick_spi_slave;

  localparam int H = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en;
  logic        sclk_v [5];
  logic        ss_v   [5];
  logic        mosi_v [5];
  logic [7:0]  tx_v   [5];
  logic        miso_w [5];
  logic        dv_w   [5];
  logic        fe_w   [5];
  logic        busy_w [5];
  logic [15:0] in_w   [5];

  int asserts = 0;
  int fails   = 0;

  int          dvcnt   [5] = '{default: 0};
  logic [15:0] last_in [5] = '{default: '0};
  logic [15:0] prev_in [5] = '{default: '0};

  logic [31:0] mb;

  for (genvar g = 0; g < 5; g++) begin : gd
    quick_spi_slave #(
      .INCOMING_DATA_WIDTH(16),
      .OUTGOING_DATA_WIDTH(8),
      .BITS_ORDER(g != 4),
      .CPOL(g == 2 || g == 3),
      .CPHA(g == 1 || g == 3),
      .MISO_IDLE_VALUE(1'b0)
    ) u_dut (
      .clk(clk),
      .reset_n(rst_n),
      .enable(en),
      .sclk(sclk_v[g]),
      .ss_n(ss_v[g]),
      .mosi(mosi_v[g]),
      .miso(miso_w[g]),
      .outgoing_data(tx_v[g]),
      .incoming_data(in_w[g]),
      .data_valid(dv_w[g]),
      .frame_error(fe_w[g]),
      .busy(busy_w[g])
    );
  end

  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (dv_w[i] === 1'b1) begin
        dvcnt[i]   <= dvcnt[i] + 1;
        prev_in[i] <= last_in[i];
        last_in[i] <= in_w[i];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] txw(input bit lsb);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[lsb ? i : 7 - i] = mb[i];
    return r;
  endfunction

  // Master side: drives sclk/mosi, records miso at each master sample point
  task automatic frame(input int d, input bit cpol, input bit cpha,
                       input bit lsb, input logic [31:0] data,
                       input int nb, input bit raise);
    mb = '0;
    sclk_v[d] = cpol;
    ss_v[d]   = 1'b0;
    mosi_v[d] = 1'b0;
    tick(H);
    for (int i = 0; i < nb; i++) begin
      logic b;
      b = lsb ? data[i] : data[nb - 1 - i];
      if (!cpha) begin
        mosi_v[d] = b;
        tick(H);
        mb[i] = miso_w[d];
        sclk_v[d] = ~cpol;
        tick(H);
        sclk_v[d] = cpol;
      end else begin
        sclk_v[d] = ~cpol;
        mosi_v[d] = b;
        tick(H);
        mb[i] = miso_w[d];
        sclk_v[d] = cpol;
        tick(H);
      end
    end
    tick(H);
    chk($sformatf("dut%0d_busy_mid", d), busy_w[d], 1'b1);
    if (raise) ss_v[d] = 1'b1;
  endtask

  task automatic wait_dv(input int d, output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (dv_w[d] === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run(input int d, input bit cpol, input bit cpha,
                     input bit lsb, input logic [31:0] data, input int nb,
                     input logic [15:0] ein, input logic efe);
    int c0;
    int lat;
    c0 = dvcnt[d];
    frame(d, cpol, cpha, lsb, data, nb, 1'b1);
    wait_dv(d, lat);
    chk($sformatf("dut%0d_latency", d), lat, 4);
    chk($sformatf("dut%0d_rx", d), in_w[d], ein);
    chk($sformatf("dut%0d_frame_error", d), fe_w[d], efe);
    tick(3);
    chk($sformatf("dut%0d_pulses", d), dvcnt[d] - c0, 1);
    chk($sformatf("dut%0d_busy_after", d), busy_w[d], 1'b0);
    chk($sformatf("dut%0d_miso_idle", d), miso_w[d], 1'b0);
    chk($sformatf("dut%0d_rx_hold", d), in_w[d], ein);
  endtask

  initial begin
    int c0;
    #1ms;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int c0;
    int lat;
    rst_n = 1'b0;
    en    = 1'b1;
    for (int d = 0; d < 5; d++) begin
      sclk_v[d] = (d == 2 || d == 3);
      ss_v[d]   = 1'b1;
      mosi_v[d] = 1'b0;
      tx_v[d]   = 8'h00;
    end
    tick(3);
    chk("rst_miso", miso_w[0], 1'b0);
    chk("rst_rx", in_w[0], 16'h0000);
    chk("rst_dv", dv_w[0], 1'b0);
    chk("rst_fe", fe_w[0], 1'b0);
    chk("rst_busy", busy_w[0], 1'b0);
    rst_n = 1'b1;
    tick(5);

    tx_v[0] = 8'hA5;
    run(0, 0, 0, 0, 32'h3C5A, 16, 16'h3C5A, 1'b0);
    chk("a5_tx_word", txw(0), 8'hA5);
    chk("a5_tx_tail_idle", mb[15:8], 8'h00);

    for (int d = 0; d < 4; d++) begin
      tx_v[d] = 8'h81;
      run(d, (d == 2 || d == 3), (d == 1 || d == 3), 0,
          32'hBEEF, 16, 16'hBEEF, 1'b0);
      chk($sformatf("mode%0d_tx_word", d), txw(0), 8'h81);
    end

    tx_v[4] = 8'h5B;
    run(4, 0, 0, 1, 32'h0001, 16, 16'h0001, 1'b0);
    chk("lsb_first_miso_bit", mb[0], 1'b1);
    chk("lsb_tx_word", txw(1), 8'h5B);

    run(0, 0, 0, 0, 32'h1234F, 20, 16'h1234, 1'b0);

    run(0, 0, 0, 0, 32'h2CE, 10, 16'h02CE, 1'b1);

    c0 = dvcnt[0];
    en = 1'b0;
    ss_v[0] = 1'b0;
    tick(10);
    chk("disabled_busy", busy_w[0], 1'b0);
    ss_v[0] = 1'b1;
    tick(8);
    en = 1'b1;
    chk("disabled_no_dv", dvcnt[0] - c0, 0);

    c0 = dvcnt[0];
    frame(0, 0, 0, 0, 32'h1357, 16, 1'b1);
    tick(2);
    frame(0, 0, 0, 0, 32'h2468, 16, 1'b1);
    wait_dv(0, lat);
    chk("b2b_latency", lat, 4);
    chk("b2b_rx2", in_w[0], 16'h2468);
    tick(3);
    chk("b2b_rx1", prev_in[0], 16'h1357);
    chk("b2b_pulses", dvcnt[0] - c0, 2);

    tx_v[0] = 8'hFF;
    c0 = dvcnt[0];
    frame(0, 0, 0, 0, 32'h15, 5, 1'b0);
    chk("abort_miso_before", miso_w[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy_w[0], 1'b0);
    chk("abort_miso", miso_w[0], 1'b0);
    chk("abort_rx_clear", in_w[0], 16'h0000);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    chk("abort_no_restart", busy_w[0], 1'b0);
    ss_v[0] = 1'b1;
    tick(6);
    chk("abort_no_dv", dvcnt[0] - c0, 0);
    tx_v[0] = 8'h3C;
    run(0, 0, 0, 0, 32'hCAFE, 16, 16'hCAFE, 1'b0);
    chk("cafe_tx_word", txw(0), 8'h3C);
    chk("cafe_total_pulses", dvcnt[0] - c0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
